// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 scan sequencer.
//   - scan_state_e : sequencer FSM states (GAP exists only with HUB75_ROW_GAP_EN)
//   - ROW_W        : width of the panel row address (A..D)
//   - FLD_*        : position of each colour field in rd_data, in units of BPC bits
// Optional feature macro: HUB75_ROW_GAP_EN
package hub75_pkg;

    localparam int unsigned ROW_W      = 4;
    localparam int unsigned NUM_FIELDS = 6;

    // rd_data = {r0, g0, b0, r1, g1, b1}; field f occupies bits [f*BPC +: BPC]
    localparam int unsigned FLD_R0 = 5;
    localparam int unsigned FLD_G0 = 4;
    localparam int unsigned FLD_B0 = 3;
    localparam int unsigned FLD_R1 = 2;
    localparam int unsigned FLD_G1 = 1;
    localparam int unsigned FLD_B1 = 0;

`ifdef HUB75_ROW_GAP_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY,
        ST_GAP
    } scan_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_LATCH,
        ST_DISPLAY
    } scan_state_e;
`endif

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer: down-counter that sets the LED on-time of one bit plane.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (one cycle before the timed interval starts)
//   load_val  : interval length in cycles
//   expire    : high in the last cycle of the interval
module hub75_bcm_timer #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count N..1 spans exactly N cycles after the load.
    always_comb begin
        expire = (cnt_q == CNT_W'(1));
    end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: HUB75 32-row panel scan sequencer with bit-angle modulation.
// Reads pixel words from a frame buffer, shifts one bit plane per pass into the
// column drivers, latches it, and lights it for BASE_ON<<plane cycles, stepping
// through 16 scan rows per frame.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : run scanning (checked at frame boundaries)
//   rd_addr / rd_data : frame-buffer read port {row, col}; data one cycle later
//   A, B, C, D        : panel row address bits 0..3
//   R0..B1            : column data, top/bottom half
//   SCLK, LAT, OE     : shift clock, latch strobe, output enable (active-low)
//   frame_done        : one-cycle pulse after the last plane of row 15
// Optional feature macro: HUB75_ROW_GAP_EN inserts ROW_GAP blank cycles on
// each row change, switching A..D at the start of the blank.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned COLS    = 64,
    parameter int unsigned BPC     = 4,
    parameter int unsigned BASE_ON = 8,
    parameter int unsigned ROW_GAP = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    output logic [ROW_W+$clog2(COLS)-1:0]   rd_addr,
    input  logic [6*BPC-1:0]                rd_data,
    output logic                            A,
    output logic                            B,
    output logic                            C,
    output logic                            D,
    output logic                            R0,
    output logic                            G0,
    output logic                            B0,
    output logic                            R1,
    output logic                            G1,
    output logic                            B1,
    output logic                            SCLK,
    output logic                            LAT,
    output logic                            OE,
    output logic                            frame_done
);

    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned CNT_W   = $clog2(BASE_ON) + BPC;
    localparam int unsigned ADDR_W  = ROW_W + COL_W;

    scan_state_e              state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [PLANE_W-1:0]       plane_q, plane_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic                     phase_q, phase_d;
    logic [ROW_W-1:0]         ad_q, ad_d;
    logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
    logic [NUM_FIELDS-1:0]    pix_q, pix_d;
    logic                     frame_done_q, frame_done_d;

    logic                     timer_load;
    logic [CNT_W-1:0]         timer_val;
    logic                     timer_expire;

    logic [NUM_FIELDS-1:0]    plane_bits;
    logic [NUM_FIELDS-1:0]    pins;
    logic [ROW_W-1:0]         row_inc;
    logic [COL_W-1:0]         col_inc;
    logic                     plane_last;

`ifdef HUB75_ROW_GAP_EN
    localparam int unsigned GAP_W = $clog2(ROW_GAP + 1);
    logic [GAP_W-1:0]         gap_q, gap_d;
`else
    // ROW_GAP only matters when the blanking gap is built in.
    logic                     unused_row_gap;
    always_comb begin
        unused_row_gap = (ROW_GAP != 0);
    end
`endif

    // Select bit `plane` of every colour field in the incoming pixel word.
    always_comb begin
        plane_bits = '0;
        for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
            plane_bits[f] = rd_data[f*BPC + 32'(plane_q)];
        end
    end

    always_comb begin
        row_inc    = row_q + 1'b1;
        col_inc    = col_q + 1'b1;
        plane_last = (plane_q == PLANE_W'(BPC - 1));
        timer_val  = CNT_W'(BASE_ON) << plane_q;
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        col_d        = col_q;
        phase_d      = phase_q;
        ad_d         = ad_q;
        rd_addr_d    = rd_addr_q;
        pix_d        = pix_q;
        frame_done_d = 1'b0;
        timer_load   = 1'b0;
`ifdef HUB75_ROW_GAP_EN
        gap_d        = gap_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d   = ST_FETCH;
                    row_d     = '0;
                    plane_d   = '0;
                    rd_addr_d = '0;
                end
            end

            ST_FETCH: begin
                col_d   = '0;
                phase_d = 1'b0;
                state_d = ST_SHIFT;
`ifdef HUB75_ROW_GAP_EN
                // The read address stays put through the gap, so the first
                // pixel word is still on rd_data when shifting starts.
                if ((plane_q == '0) && (row_q != ad_q)) begin
                    state_d = ST_GAP;
                    ad_d    = row_q;
                    gap_d   = GAP_W'(ROW_GAP);
                end
`endif
            end

`ifdef HUB75_ROW_GAP_EN
            ST_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = ST_SHIFT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
`endif

            ST_SHIFT: begin
                if (!phase_q) begin
                    // Word for this column is on rd_data now; hold it for the
                    // SCLK-high half and request the next column.
                    phase_d   = 1'b1;
                    pix_d     = plane_bits;
                    rd_addr_d = {row_q, col_inc};
                end else begin
                    phase_d = 1'b0;
                    if (col_q == COL_W'(COLS - 1)) begin
                        state_d = ST_LATCH;
                        // Row address moves on the edge into LATCH so it is
                        // never seen changing while OE is active.
                        if (plane_q == '0) begin
                            ad_d = row_q;
                        end
                    end else begin
                        col_d = col_inc;
                    end
                end
            end

            ST_LATCH: begin
                state_d    = ST_DISPLAY;
                timer_load = 1'b1;
            end

            ST_DISPLAY: begin
                if (timer_expire) begin
                    state_d = ST_FETCH;
                    if (!plane_last) begin
                        plane_d   = plane_q + 1'b1;
                        rd_addr_d = {row_q, {COL_W{1'b0}}};
                    end else begin
                        plane_d   = '0;
                        row_d     = row_inc;
                        rd_addr_d = {row_inc, {COL_W{1'b0}}};
                        if (row_q == '1) begin
                            frame_done_d = 1'b1;
                            if (!en) begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            ad_q         <= '0;
            rd_addr_q    <= '0;
            pix_q        <= '0;
            frame_done_q <= 1'b0;
`ifdef HUB75_ROW_GAP_EN
            gap_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            ad_q         <= ad_d;
            rd_addr_q    <= rd_addr_d;
            pix_q        <= pix_d;
            frame_done_q <= frame_done_d;
`ifdef HUB75_ROW_GAP_EN
            gap_q        <= gap_d;
`endif
        end
    end

    hub75_bcm_timer #(
        .CNT_W (CNT_W)
    ) u_bcm_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .expire   (timer_expire)
    );

    // Data pins show the live word in phase 0 and the held copy in phase 1,
    // so they are stable across the SCLK rising edge.
    always_comb begin
        pins = '0;
        if (state_q == ST_SHIFT) begin
            pins = phase_q ? pix_q : plane_bits;
        end
        R0 = pins[FLD_R0];
        G0 = pins[FLD_G0];
        B0 = pins[FLD_B0];
        R1 = pins[FLD_R1];
        G1 = pins[FLD_G1];
        B1 = pins[FLD_B1];

        OE         = (state_q != ST_DISPLAY);
        LAT        = (state_q == ST_LATCH);
        SCLK       = (state_q == ST_SHIFT) && phase_q;
        {D, C, B, A} = ad_q;
        rd_addr    = rd_addr_q;
        frame_done = frame_done_q;
    end

endmodule

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Scan sequencer for the 32-row HUB75 RGB panel driven by `LED_top`. It reads 6-channel pixel words from a frame buffer and shifts one bit plane per pass into the panel column drivers. It then latches the plane and enables the LEDs for a binary-weighted time (bit-angle modulation), stepping the 4-bit row address A–D through all 16 scan rows. It replaces the free-running counter logic in `LED_top` and is the only block that drives panel pins.

## Interface
- `COLS`, 64: columns per scan row; power of two, ≥2
- `BPC`, 4: bits per colour channel (number of bit planes)
- `BASE_ON`, 8: OE-active cycles for plane 0; plane p gets `BASE_ON<<p`
- `ROW_GAP`, 4: blank cycles on row change; used only with `HUB75_ROW_GAP_EN`

- `clk` in 1: system clock, all logic on rising edge
- `rst` in 1: synchronous, active-high reset
- `en` in 1: run scanning; sampled at frame boundaries
- `rd_addr` out 4+log2(COLS): frame-buffer read address {row[3:0], col}
- `rd_data` in 6*BPC: {r0,g0,b0,r1,g1,b1}, each BPC bits, r0 in MSBs; valid 1 cycle after `rd_addr`
- `A`,`B`,`C`,`D` out 1 each: row address bits 0..3
- `R0`,`G0`,`B0`,`R1`,`G1`,`B1` out 1 each: column data, top/bottom half
- `SCLK` out 1: panel shift clock
- `LAT` out 1: latch strobe, active-high
- `OE` out 1: output enable, active-low
- `frame_done` out 1: one-cycle pulse after the last plane of row 15

## Operation
- FSM states: IDLE, FETCH, SHIFT, LATCH, DISPLAY, plus GAP when the macro is set.
- **IDLE**
  - `OE`=1, `SCLK`=0, `LAT`=0.
  - Leaves IDLE when `en`=1, with row=0, plane=0 → FETCH.
- **FETCH (1 cycle)**
  - Issues `rd_addr`={row, 0}.
  - Then goes to SHIFT, or to GAP when plane=0, row≠previous row, and the macro is set.
- **SHIFT (2·COLS cycles)**
  - Column c uses two cycles: phase 0 and phase 1.
  - Phase 0: `SCLK`=0 and the data pins show bit `plane` of the registered `rd_data` for column c.
  - Phase 1: `SCLK`=1 and `rd_addr`={row, c+1} is issued.
  - `OE`=1 throughout. After column COLS−1 phase 1 → LATCH.
- **LATCH (1 cycle)**
  - `LAT`=1, `OE`=1, `SCLK`=0.
  - A–D update to `row` in this cycle when plane=0.
  - → DISPLAY.
- **DISPLAY (`BASE_ON<<plane` cycles)**
  - `OE`=0; the down-counter loads on entry.
  - On expiry: if plane<BPC−1, then plane++ → FETCH.
  - Otherwise plane=0 and row++ (wraps 15→0) → FETCH.
  - On the 15→0 wrap, pulse `frame_done`. If `en`=0 at that point → IDLE; otherwise continue.
- `en` deasserted mid-frame: the current frame completes, then the FSM goes to IDLE. There is no abort.
- `rd_data` changing outside the cycle after `rd_addr` is ignored.
- Row counter is 4 bits with modulo-16 wrap. Plane counter is log2(BPC) bits. Display counter width is log2(BASE_ON)+BPC.

## Timing
- Reset values:
  - all data pins, A–D, `SCLK`, `LAT`, `frame_done` = 0
  - `OE`=1
  - `rd_addr`=0
  - FSM in IDLE
- Cycles per plane p = 1 + 2·COLS + 1 + (BASE_ON<<p).
- Per row: sum over p, plus ROW_GAP when the macro is set. Per frame: 16 × per-row.
- Pixel read latency is exactly 1 cycle; no stall input.
- `OE`=0 only in DISPLAY. `OE` and `LAT` are never asserted together. A–D never change while `OE`=0.
- `rst` at any cycle: all outputs take reset values on the next edge, the FSM goes to IDLE, and counters clear.

## Configuration
- `HUB75_ROW_GAP_EN` defined:
  - On every row change, insert GAP for ROW_GAP cycles between FETCH and SHIFT.
  - During GAP: `OE`=1, `SCLK`=0, `LAT`=0.
  - A–D switch to the new row on GAP entry, so the switch happens while blanked and suppresses ghosting.
- Not defined: no GAP state, and ROW_GAP is ignored. Timing follows the formula above with no gap term.

## Structure
- `hub75_pkg` holds the FSM state enum, the row-address width constant (4), and the `rd_data` field-offset constants.
- One sub-module, `hub75_bcm_timer`:
  - load value `BASE_ON<<plane`, counts down, outputs `expire`
  - instantiated once for DISPLAY timing

## Test plan
All scenarios use COLS=4, BPC=2, BASE_ON=2 unless stated.

- **Reset/idle:** `rst`=1 for 2 cycles, `en`=0 → `OE`=1, all other outputs 0, no `SCLK` edges over 50 cycles.
- **Shift data:** model returns r0=2'b01 for all pixels → plane 0 shifts R0=1 on 4 `SCLK` rises, plane 1 shifts R0=0; `LAT` pulses once per plane.
- **BCM weights:** count `OE`=0 cycles → plane 0 gives 2, plane 1 gives 4; per row 26 cycles; `frame_done` every 416 cycles.
- **Row wrap:** run 1 frame → A–D sequence 0..15 then 0; A–D change only when `OE`=1.
- **Mid-frame stop and reset:**
  - `en`→0 at row 5 → finishes row 15, `frame_done` pulses, then IDLE.
  - `rst` at a DISPLAY cycle → `OE`=1 next cycle.
- **Macro (`HUB75_ROW_GAP_EN`, ROW_GAP=4):** per-row period becomes 30 cycles; 4 blank cycles with new A–D before the first `SCLK` of each row.
